// File: rtl/baud_gen_nco.sv
// baud_gen_nco: fractional (NCO) baud generator for the UART path.
//
// A phase accumulator advances by a per-rate increment on every enabled
// clock. Each accumulator carry produces one oversampled sample_tick; every
// OVERSAMPLE-th sample_tick also raises baud_tick. The carry is dropped and
// the residue kept, so the fractional part carries forward without drift.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       accumulator advances only while high
//   resync       one-cycle pulse, restarts phase and sample index at zero
//   baud_sel     rate select, 300 .. 115200 bit/s (see BAUD table below)
//   sample_tick  one-cycle pulse at OVERSAMPLE x baud rate
//   baud_tick    one-cycle pulse at baud rate, always with a sample_tick
//   sample_idx   index of the current sample within the bit

module baud_gen_nco #(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24,
  localparam int CNT_W     = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             resync,
  input  logic [2:0]       baud_sel,
  output logic             sample_tick,
  output logic             baud_tick,
  output logic [CNT_W-1:0] sample_idx
);

  // Increment = round(baud * OVERSAMPLE * 2^ACC_W / CLK_HZ), 64-bit math.
  function automatic logic [63:0] calc_inc(input int k);
    logic [63:0] baud;
    case (k)
      0:       baud = 64'd300;
      1:       baud = 64'd1200;
      2:       baud = 64'd4800;
      3:       baud = 64'd9600;
      4:       baud = 64'd19200;
      5:       baud = 64'd38400;
      6:       baud = 64'd57600;
      default: baud = 64'd115200;
    endcase
    return (baud * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_HZ / 2))
           / 64'(CLK_HZ);
  endfunction

  localparam logic [63:0] INC_TAB [8] = '{
    calc_inc(0), calc_inc(1), calc_inc(2), calc_inc(3),
    calc_inc(4), calc_inc(5), calc_inc(6), calc_inc(7)
  };

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  // Parameter sanity: an increment of zero never ticks, and one at or above
  // half the phase range would ask for sample_tick faster than clk/2.
  if (OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
      (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $fatal(1, "baud_gen_nco: OVERSAMPLE must be a power of two in 4..64");
  end
  if (ACC_W < 16 || ACC_W > 32) begin : g_bad_acc_w
    $fatal(1, "baud_gen_nco: ACC_W must be in 16..32");
  end
  for (genvar k = 0; k < 8; k++) begin : g_inc_chk
    if (INC_TAB[k] == 64'd0 ||
        INC_TAB[k] >= (64'd1 << (ACC_W - 1))) begin : g_bad_inc
      $fatal(1, "baud_gen_nco: increment out of range for baud_sel %0d", k);
    end
  end

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       sel_q;
  logic             sample_tick_q;
  logic             baud_tick_q;

  logic [ACC_W-1:0] inc_sel;
  logic [ACC_W:0]   sum_d;

  // Increment follows the registered select so a rate change only takes
  // effect on the edge after it has been accepted.
  assign inc_sel = INC_TAB[sel_q][ACC_W-1:0];
  assign sum_d   = {1'b0, acc_q} + {1'b0, inc_sel};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      sel_q         <= 3'b000;
      sample_tick_q <= 1'b0;
      baud_tick_q   <= 1'b0;
    end else if (baud_sel != sel_q) begin
      sel_q         <= baud_sel;
      acc_q         <= '0;
      cnt_q         <= '0;
      sample_tick_q <= 1'b0;
      baud_tick_q   <= 1'b0;
    end else if (resync) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      sample_tick_q <= 1'b0;
      baud_tick_q   <= 1'b0;
    end else if (!enable) begin
      sample_tick_q <= 1'b0;
      baud_tick_q   <= 1'b0;
    end else begin
      // Carry is dropped, residue kept: fractional carry-forward.
      acc_q         <= sum_d[ACC_W-1:0];
      sample_tick_q <= sum_d[ACC_W];
      if (sum_d[ACC_W]) begin
        cnt_q       <= cnt_q + CNT_W'(1);
        baud_tick_q <= (cnt_q == CNT_LAST);
      end else begin
        baud_tick_q <= 1'b0;
      end
    end
  end

  assign sample_tick = sample_tick_q;
  assign baud_tick   = baud_tick_q;
  assign sample_idx  = cnt_q;

endmodule

// File: tb/tb_baud_gen_nco.sv
// Directed testbench for baud_gen_nco with default parameters.
// Hand-computed increments: INC[111]=618475, INC[011]=51540, INC[000]=1611.
module tb_baud_gen_nco;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       resync;
  logic [2:0] baud_sel;
  logic       sample_tick;
  logic       baud_tick;
  logic [3:0] sample_idx;

  int n_tests = 0;
  int n_fail  = 0;

  baud_gen_nco dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .resync      (resync),
    .baud_sel    (baud_sel),
    .sample_tick (sample_tick),
    .baud_tick   (baud_tick),
    .sample_idx  (sample_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock edge and sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until sample_tick is seen high; -1 if the bound expires.
  task automatic edges_to_st(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (sample_tick) begin
        n = i;
        break;
      end
    end
  endtask

  int n, e, st_cnt, bt_cnt, bad_width, prev_st, idx_hold, p, total, ok;

  initial begin
    reset = 1'b1; enable = 1'b1; resync = 1'b0; baud_sel = 3'b111;

    // Reset values
    step(); step();
    chk("rst_st",  int'(sample_tick), 0);
    chk("rst_bt",  int'(baud_tick),   0);
    chk("rst_idx", int'(sample_idx),  0);
    reset = 1'b0;

    // First edge after reset with baud_sel!=000 is a rate change
    step();
    chk("rc_st",  int'(sample_tick), 0);
    chk("rc_idx", int'(sample_idx),  0);

    // 115200: first sample_tick after 28 edges, first baud_tick after 435
    edges_to_st(100, n);
    chk("first_st_edges", n, 28);
    chk("first_st_idx", int'(sample_idx), 1);
    chk("first_st_bt",  int'(baud_tick),  0);
    e = n; st_cnt = 1;
    for (int i = 0; i < 1000; i++) begin
      step(); e++;
      if (sample_tick) st_cnt++;
      if (baud_tick) break;
    end
    chk("first_bt_edges", e, 435);
    chk("first_bt_st_count", st_cnt, 16);
    chk("first_bt_with_st", int'(sample_tick), 1);
    chk("first_bt_idx", int'(sample_idx), 0);

    // Long run from acc=0 (resync): 30000 edges -> 1105 samples, 69 bauds
    resync = 1'b1; step(); resync = 1'b0;
    st_cnt = 0; bt_cnt = 0; bad_width = 0; prev_st = 0;
    for (int i = 0; i < 30000; i++) begin
      step();
      if (sample_tick) st_cnt++;
      if (baud_tick) bt_cnt++;
      if (sample_tick && prev_st != 0) bad_width++;
      if (baud_tick && !sample_tick) bad_width++;
      prev_st = int'(sample_tick);
    end
    chk("long_st_count", st_cnt, 1105);
    chk("long_bt_count", bt_cnt, 69);
    chk("long_pulse_shape", bad_width, 0);

    // 300 baud: first tick after 10415 enabled edges, 5000-cycle gap
    baud_sel = 3'b000; step();
    chk("rc000_idx", int'(sample_idx), 0);
    st_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (sample_tick) st_cnt++;
    end
    idx_hold = int'(sample_idx);
    enable = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (sample_tick || baud_tick) st_cnt++;
    end
    chk("gap_no_ticks", st_cnt, 0);
    chk("gap_idx_hold", int'(sample_idx), idx_hold);
    enable = 1'b1;
    edges_to_st(6000, n);
    chk("st300_after_gap", n, 5415);
    chk("st300_idx", int'(sample_idx), 1);

    // Resync at sample_idx 9 while running at 115200
    baud_sel = 3'b111; step();
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sample_idx == 4'd9) begin ok = 1; break; end
      step();
    end
    chk("reach_idx9", ok, 1);
    resync = 1'b1;  // enable is also high: resync must win
    step();
    resync = 1'b0;
    chk("resync_idx", int'(sample_idx), 0);
    chk("resync_st",  int'(sample_tick), 0);
    chk("resync_bt",  int'(baud_tick),  0);
    edges_to_st(100, n);
    chk("resync_next_st", n, 28);

    // Rate switch 111 -> 011 mid-bit
    step(); step();
    baud_sel = 3'b011; step();
    chk("sw_st",  int'(sample_tick), 0);
    chk("sw_bt",  int'(baud_tick),   0);
    chk("sw_idx", int'(sample_idx),  0);
    edges_to_st(400, n);
    chk("sw_first_st", n, 326);
    total = 0; ok = 1;
    for (int k = 0; k < 10; k++) begin
      edges_to_st(400, p);
      if (p != 325 && p != 326) ok = 0;
      total += p;
    end
    chk("sw_period_325_326", ok, 1);
    chk("sw_10_periods", total, 3255);

    // Async reset while sample_tick is high
    edges_to_st(400, n);
    chk("pre_rst_st", int'(sample_tick), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_st",  int'(sample_tick), 0);
    chk("arst_bt",  int'(baud_tick),   0);
    chk("arst_idx", int'(sample_idx),  0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_rc_st",  int'(sample_tick), 0);
    chk("post_rst_rc_idx", int'(sample_idx),  0);
    edges_to_st(400, n);
    chk("post_rst_first_st", n, 326);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
